ship_life_ctl: RTL

- Sequences the player ship's life cycle: alive, dying (explosion hold), respawn with invulnerability blink, and game over.
- Replaces the ad-hoc latch/counter/unlock chain between collision detection and the ship renderer, missile controller and lives display.
- Consumes the collision level and frame timing. Drives dead/visible/fire-enable flags and the lives counters for the ship draw stage, missile control and life icons.

---
 rtl/ship_life_ctl_pkg.sv | 35 +++
 rtl/ship_life_ctl_edge_pulse.sv | 29 ++
 rtl/ship_life_ctl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ship_life_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ship_life_ctl_pkg
// Description : State encodings, default timing constants and saturating
//               4-bit helpers shared by the ship life-cycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ship_life_ctl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ALIVE     = 3'd1,
      ST_DYING     = 3'd2,
      ST_RESPAWN   = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_t;

   localparam int c_LIVES_DEFAULT         = 3;
   localparam int c_DYING_FRAMES_DEFAULT  = 60;
   localparam int c_INVULN_FRAMES_DEFAULT = 120;
   localparam int c_BLINK_FRAMES_DEFAULT  = 8;
   localparam int c_FCNT_W_DEFAULT        = 8;

   // Increment that sticks at 15 instead of wrapping
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // Decrement that sticks at 0 instead of wrapping
   function automatic logic [3:0] sat_dec4(input logic [3:0] v);
      return (v == 4'h0) ? v : v - 4'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ship_life_ctl_edge_pulse.sv
`default_nettype none
// ============================================================================
// Module      : edge_pulse
// Description : Single-cycle pulse on a 0->1 transition of a level input,
//               derived from a registered copy of that input.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_pulse (
   input  logic pclk,
   input  logic rst,
   input  logic i_sig,
   output logic o_rise
);

   logic r_prev;

   // Remember last cycle's level so a rise can be seen
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= i_sig;
      end
   end

   assign o_rise = i_sig & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/ship_life_ctl.sv
`default_nettype none
// ============================================================================
// Module      : ship_life_ctl
// Description : Player ship life cycle: alive, dying hold, blinking
//               invulnerable respawn and game over, with lives/deaths count.
// Revision    : 1.0 - initial release
// ============================================================================
module ship_life_ctl
   import ship_life_ctl_pkg::*;
#(
   parameter int LIVES         = c_LIVES_DEFAULT,
   parameter int DYING_FRAMES  = c_DYING_FRAMES_DEFAULT,
   parameter int INVULN_FRAMES = c_INVULN_FRAMES_DEFAULT,
   parameter int BLINK_FRAMES  = c_BLINK_FRAMES_DEFAULT,
   parameter int FCNT_W        = c_FCNT_W_DEFAULT
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic       vsync_in,
   input  logic       hit,
   input  logic       start_button,
   output logic       ship_dead,
   output logic       ship_visible,
   output logic       fire_enable,
   output logic [3:0] lives_left,
   output logic [3:0] dead_count,
   output logic       game_over,
   output logic [2:0] state_out
);

   localparam logic [FCNT_W-1:0] c_DYING_LAST  = FCNT_W'(DYING_FRAMES - 1);
   localparam logic [FCNT_W-1:0] c_INVULN_LAST = FCNT_W'(INVULN_FRAMES - 1);
   localparam int                c_BLINK_BIT   = $clog2(BLINK_FRAMES);

   logic              w_frame_tick;
   logic              w_start_pulse;

   state_t            r_state;
   logic [FCNT_W-1:0] r_cnt;
   logic [3:0]        r_lives;
   logic [3:0]        r_dead_cnt;
   logic              r_ship_dead;
   logic              r_ship_visible;
   logic              r_fire_enable;
   logic              r_game_over;

   state_t            w_next_state;
   logic [FCNT_W-1:0] w_next_cnt;
   logic [3:0]        w_next_lives;
   logic [3:0]        w_next_dead_cnt;

   edge_pulse u_vsync_edge (
      .pclk   (pclk),
      .rst    (rst),
      .i_sig  (vsync_in),
      .o_rise (w_frame_tick)
   );

   edge_pulse u_start_edge (
      .pclk   (pclk),
      .rst    (rst),
      .i_sig  (start_button),
      .o_rise (w_start_pulse)
   );

   // Next state, frame counter and life bookkeeping
   always_comb begin
      w_next_state    = r_state;
      w_next_cnt      = r_cnt;
      w_next_lives    = r_lives;
      w_next_dead_cnt = r_dead_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_start_pulse) begin
               w_next_state = ST_RESPAWN;
               w_next_cnt   = '0;
            end
         end
         ST_ALIVE: begin
            // A coincident frame tick is irrelevant here: only hit matters
            if (hit) begin
               w_next_state    = ST_DYING;
               w_next_cnt      = '0;
               w_next_lives    = sat_dec4(r_lives);
               w_next_dead_cnt = sat_inc4(r_dead_cnt);
            end
         end
         ST_DYING: begin
            if (w_frame_tick) begin
               if (r_cnt == c_DYING_LAST) begin
                  w_next_state = (r_lives == 4'd0) ? ST_GAME_OVER : ST_RESPAWN;
                  w_next_cnt   = '0;
               end else if (r_cnt < c_DYING_LAST) begin
                  w_next_cnt = r_cnt + 1'b1;
               end
            end
         end
         ST_RESPAWN: begin
            // hit deliberately ignored: the ship is invulnerable
            if (w_frame_tick) begin
               if (r_cnt == c_INVULN_LAST) begin
                  w_next_state = ST_ALIVE;
                  w_next_cnt   = '0;
               end else if (r_cnt < c_INVULN_LAST) begin
                  w_next_cnt = r_cnt + 1'b1;
               end
            end
         end
         ST_GAME_OVER: begin
            if (w_start_pulse) begin
               w_next_state    = ST_RESPAWN;
               w_next_cnt      = '0;
               w_next_lives    = 4'(LIVES);
               w_next_dead_cnt = 4'd0;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_next_cnt   = '0;
         end
      endcase
   end

   // State register with outputs decoded from the next state so they are registered
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_lives        <= 4'(LIVES);
         r_dead_cnt     <= 4'd0;
         r_ship_dead    <= 1'b1;
         r_ship_visible <= 1'b0;
         r_fire_enable  <= 1'b0;
         r_game_over    <= 1'b0;
      end else begin
         r_state        <= w_next_state;
         r_cnt          <= w_next_cnt;
         r_lives        <= w_next_lives;
         r_dead_cnt     <= w_next_dead_cnt;
         r_ship_dead    <= (w_next_state == ST_IDLE) || (w_next_state == ST_DYING) ||
                           (w_next_state == ST_GAME_OVER);
         r_ship_visible <= (w_next_state == ST_ALIVE) ||
                           ((w_next_state == ST_RESPAWN) && !w_next_cnt[c_BLINK_BIT]);
         r_fire_enable  <= (w_next_state == ST_ALIVE);
         r_game_over    <= (w_next_state == ST_GAME_OVER);
      end
   end

   assign ship_dead    = r_ship_dead;
   assign ship_visible = r_ship_visible;
   assign fire_enable  = r_fire_enable;
   assign lives_left   = r_lives;
   assign dead_count   = r_dead_cnt;
   assign game_over    = r_game_over;
   assign state_out    = r_state;

endmodule
`default_nettype wire
